// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter that time-shares one 4-digit 7-segment driver between four
// requesters, with per-owner dwell time, optional requester-0 preemption and value clamping.
module seg_disp_arbiter #(
  parameter int unsigned HOLD_CYC = 2000,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned PRIO0    = 0,
  parameter int unsigned MAXVAL   = 9999
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [55:0] req_data,
  output logic [3:0]  gnt,
  output logic [13:0] disp_data,
  output logic [1:0]  disp_src,
  output logic        active,
  output logic        ovf
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [13:0]      MAXV   = 14'(MAXVAL);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [13:0]      data_q, data_d;
  logic [1:0]       src_q, src_d;
  logic             ovf_q, ovf_d;

  logic [13:0] vals [4];
  logic [13:0] sel;
  logic [1:0]  rr_cand, rr_idx;
  logic        rr_hit;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      vals[i] = req_data[14*i +: 14];
    end
  end

  // Search src+1 .. src+4; the current owner is visited last, so it only wins when alone.
  always_comb begin
    rr_hit  = 1'b0;
    rr_idx  = src_q;
    rr_cand = src_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      rr_cand = src_q + 2'(k);
      if (!rr_hit && req[rr_cand]) begin
        rr_hit = 1'b1;
        rr_idx = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (rr_hit) begin
          state_d = HOLD;
          src_d   = rr_idx;
          cnt_d   = RELOAD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (PRIO0 != 0 && req[0] && src_q != 2'd0) begin
          src_d = 2'd0;
          cnt_d = RELOAD;
        end else if (!req[src_q]) begin
          if (rr_hit) begin
            src_d = rr_idx;
            cnt_d = RELOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == '0) begin
          src_d = rr_idx;
          cnt_d = RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Selecting on the next owner makes a new grant show its value at the grant edge.
    sel = vals[src_d];
    if (state_d == HOLD) begin
      data_d = (sel > MAXV) ? MAXV : sel;
      ovf_d  = (sel > MAXV);
    end
    gnt_d = (state_d == HOLD) ? (4'b0001 << src_d) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      src_q   <= 2'd3;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ovf_q   <= ovf_d;
    end
  end

  assign gnt       = gnt_q;
  assign disp_data = data_q;
  assign disp_src  = src_q;
  assign active    = (state_q == HOLD);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter: two instances (pure round-robin and requester-0 priority)
// share stimulus and are compared every cycle against an abstract model plus literal checks.
module tb_seg_disp_arbiter;

  localparam int H    = 4;
  localparam int MAXV = 9999;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic [3:0]  req  = '0;
  logic [13:0] dval [4];
  logic [55:0] req_data;

  logic [3:0]  gnt_r, gnt_p;
  logic [13:0] data_r, data_p;
  logic [1:0]  src_r, src_p;
  logic        act_r, act_p, ovf_r, ovf_p;

  int checks = 0;
  int errors = 0;

  assign req_data = {dval[3], dval[2], dval[1], dval[0]};

  always #5 clk = ~clk;

  seg_disp_arbiter #(.HOLD_CYC(H), .CNT_W(11), .PRIO0(0), .MAXVAL(MAXV)) u_rr (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data),
    .gnt(gnt_r), .disp_data(data_r), .disp_src(src_r), .active(act_r), .ovf(ovf_r)
  );

  seg_disp_arbiter #(.HOLD_CYC(H), .CNT_W(11), .PRIO0(1), .MAXVAL(MAXV)) u_pr (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data),
    .gnt(gnt_p), .disp_data(data_p), .disp_src(src_p), .active(act_p), .ovf(ovf_p)
  );

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: index 0 = round-robin instance, 1 = priority instance.
  int m_owner [2];
  int m_served[2];
  int m_shown [2];
  bit m_act   [2];
  bit m_ov    [2];

  function automatic int pick(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_reset(input int m);
    m_owner[m] = 3; m_served[m] = 0; m_shown[m] = 0; m_act[m] = 0; m_ov[m] = 0;
  endtask

  task automatic m_step(input int m, input bit prio);
    int w;
    int v;
    if (!m_act[m]) begin
      w = pick(m_owner[m], req);
      if (w >= 0) begin m_owner[m] = w; m_act[m] = 1; m_served[m] = 0; end
    end else begin
      m_served[m]++;
      if (prio && req[0] && m_owner[m] != 0) begin
        m_owner[m] = 0; m_served[m] = 0;
      end else if (!req[m_owner[m]]) begin
        w = pick(m_owner[m], req);
        if (w < 0) m_act[m] = 0;
        else begin m_owner[m] = w; m_served[m] = 0; end
      end else if (m_served[m] >= H) begin
        m_owner[m] = pick(m_owner[m], req); m_served[m] = 0;
      end
    end
    if (m_act[m]) begin
      v = int'(dval[m_owner[m]]);
      m_shown[m] = (v > MAXV) ? MAXV : v;
      m_ov[m]    = (v > MAXV);
    end
  endtask

  initial begin
    m_reset(0); m_reset(1);
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin m_reset(0); m_reset(1); end
      else begin m_step(0, 1'b0); m_step(1, 1'b1); end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("m_rr_gnt",  int'(gnt_r),  m_act[0] ? (1 << m_owner[0]) : 0);
      chk("m_rr_data", int'(data_r), m_shown[0]);
      chk("m_rr_src",  int'(src_r),  m_owner[0]);
      chk("m_rr_act",  int'(act_r),  int'(m_act[0]));
      chk("m_rr_ovf",  int'(ovf_r),  int'(m_ov[0]));
      chk("m_pr_gnt",  int'(gnt_p),  m_act[1] ? (1 << m_owner[1]) : 0);
      chk("m_pr_data", int'(data_p), m_shown[1]);
      chk("m_pr_src",  int'(src_p),  m_owner[1]);
      chk("m_pr_act",  int'(act_p),  int'(m_act[1]));
      chk("m_pr_ovf",  int'(ovf_p),  int'(m_ov[1]));
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  int tv_in  [6] = '{12000, 42, 9999, 10000, 16383, 0};
  int tv_out [6] = '{9999,  42, 9999, 9999,  9999,  0};
  int tv_ovf [6] = '{1,     0,  0,    1,     1,     0};
  int base   [4] = '{100, 201, 302, 403};

  initial begin
    for (int i = 0; i < 4; i++) dval[i] = '0;
    #1 rstn = 1'b0;
    #2;
    chk("rst_gnt",  int'(gnt_r), 0);
    chk("rst_src",  int'(src_r), 3);
    chk("rst_data", int'(data_r), 0);
    chk("rst_act",  int'(act_r), 0);
    chk("rst_ovf",  int'(ovf_r), 0);
    @(negedge clk);
    #1 rstn = 1'b1;

    // single requester, then release to idle
    req = 4'b0100; dval[2] = 14'd1234;
    @(negedge clk);
    chk("t1_gnt",  int'(gnt_r), 4'b0100);
    chk("t1_src",  int'(src_r), 2);
    chk("t1_data", int'(data_r), 1234);
    chk("t1_act",  int'(act_r), 1);
    repeat (4) @(negedge clk);
    chk("t1_nogap", int'(gnt_r), 4'b0100);
    #1 req = 4'b0000;
    @(negedge clk);
    chk("t1_rel_gnt",  int'(gnt_r), 0);
    chk("t1_rel_act",  int'(act_r), 0);
    chk("t1_rel_data", int'(data_r), 1234);
    #1;

    // rotation with all four requesting
    do_reset();
    for (int i = 0; i < 4; i++) dval[i] = 14'(base[i]);
    req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("t2_rr_gnt",  int'(gnt_r), 1 << (((c - 1) / 4) % 4));
      chk("t2_rr_data", int'(data_r), base[((c - 1) / 4) % 4]);
      chk("t2_pr_gnt",  int'(gnt_p), (c % 5 == 0) ? 4'b0010 : 4'b0001);
    end
    #1;

    // clamping and live data update
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      dval[1] = 14'(tv_in[i]);
      @(negedge clk);
      chk("t3_data", int'(data_r), tv_out[i]);
      chk("t3_ovf",  int'(ovf_r),  tv_ovf[i]);
      #1;
    end

    // requester 0 preemption versus plain round-robin
    do_reset();
    req = 4'b1000; dval[3] = 14'd77; dval[0] = 14'd55;
    @(negedge clk);
    chk("t4_a_rr", int'(gnt_r), 4'b1000);
    chk("t4_a_pr", int'(gnt_p), 4'b1000);
    @(negedge clk);
    #1 req = 4'b1001;
    @(negedge clk);
    chk("t4_c_pr",      int'(gnt_p), 4'b0001);
    chk("t4_c_pr_data", int'(data_p), 55);
    chk("t4_c_rr",      int'(gnt_r), 4'b1000);
    chk("t4_c_rr_data", int'(data_r), 77);
    @(negedge clk);
    chk("t4_d_rr", int'(gnt_r), 4'b1000);
    @(negedge clk);
    chk("t4_e_rr", int'(gnt_r), 4'b0001);
    @(negedge clk);
    chk("t4_f_pr", int'(gnt_p), 4'b0001);
    @(negedge clk);
    chk("t4_g_pr", int'(gnt_p), 4'b1000);
    chk("t4_g_rr", int'(gnt_r), 4'b0001);
    #1;

    // early release hands over with a full dwell; lone owner re-granted without gap
    do_reset();
    req = 4'b1010; dval[1] = 14'd11; dval[3] = 14'd33;
    @(negedge clk);
    chk("t5_a", int'(gnt_r), 4'b0010);
    @(negedge clk);
    #1 req = 4'b1000;
    @(negedge clk);
    chk("t5_c",      int'(gnt_r), 4'b1000);
    chk("t5_c_data", int'(data_r), 33);
    repeat (3) @(negedge clk);
    chk("t5_f", int'(gnt_r), 4'b1000);
    @(negedge clk);
    chk("t5_g",    int'(gnt_r), 4'b1000);
    chk("t5_g_pr", int'(gnt_p), 4'b1000);

    // asynchronous reset mid-hold, then restart from index 0
    #1 dval[3] = 14'd15000;
    @(negedge clk);
    chk("t6_pre_ovf",  int'(ovf_r), 1);
    chk("t6_pre_data", int'(data_r), 9999);
    #2 rstn = 1'b0;
    #1;
    chk("t6_gnt",    int'(gnt_r), 0);
    chk("t6_data",   int'(data_r), 0);
    chk("t6_ovf",    int'(ovf_r), 0);
    chk("t6_act",    int'(act_r), 0);
    chk("t6_src",    int'(src_r), 3);
    chk("t6_pr_gnt", int'(gnt_p), 0);
    req = 4'b1111;
    @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("t6_first_rr", int'(gnt_r), 4'b0001);
    chk("t6_first_pr", int'(gnt_p), 4'b0001);
    chk("t6_first_src", int'(src_r), 0);

    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
